// File: rtl/led_pattern_engine.sv
// led_pattern_engine: WIDTH-bit LED pattern generator with rotate, bounce,
// fill/drain and inverted-rotate modes, a two-rate prescaler and a step strobe.
module led_pattern_engine #(
  parameter int unsigned WIDTH    = 5,
  parameter int unsigned SLOW_DIV = 4,
  parameter int unsigned FAST_DIV = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pause,
  input  logic             fast,
  input  logic             rt,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] dout,
  output logic             step
);

  localparam int unsigned CW = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;

  localparam logic [CW-1:0]    SLOW_LAST = CW'(SLOW_DIV - 1);
  localparam logic [CW-1:0]    FAST_LAST = CW'(FAST_DIV - 1);
  localparam logic [WIDTH-1:0] SEED_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] SEED_INV  = ~SEED_ONE;
  localparam logic [WIDTH-1:0] ALL_ONES  = '1;
  localparam logic [WIDTH-1:0] ALL_ZERO  = '0;

  localparam logic [1:0] MODE_ROT  = 2'b00;
  localparam logic [1:0] MODE_BNC  = 2'b01;
  localparam logic [1:0] MODE_FILL = 2'b10;

  typedef enum logic {DIR_LEFT  = 1'b0, DIR_RIGHT = 1'b1} bdir_t;
  typedef enum logic {PH_FILL   = 1'b0, PH_DRAIN  = 1'b1} phase_t;

  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [1:0]       mode_q,  mode_d;
  logic [WIDTH-1:0] dout_q,  dout_d;
  logic             step_q,  step_d;
  bdir_t            bdir_q,  bdir_d;
  phase_t           phase_q, phase_d;

  logic [CW-1:0]    div_last;
  logic             tick;
  logic             fill_bit;
  logic [WIDTH-1:0] fill_next;

  // Next-state: mode reload beats tick; pause freezes prescaler and pattern.
  always_comb begin
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    dout_d    = dout_q;
    step_d    = 1'b0;
    bdir_d    = bdir_q;
    phase_d   = phase_q;
    div_last  = fast ? FAST_LAST : SLOW_LAST;
    tick      = !pause && (cnt_q >= div_last);
    fill_bit  = (phase_q == PH_FILL);
    fill_next = rt ? {fill_bit, dout_q[WIDTH-1:1]} : {dout_q[WIDTH-2:0], fill_bit};

    if (mode != mode_q) begin
      mode_d  = mode;
      cnt_d   = '0;
      bdir_d  = DIR_LEFT;
      phase_d = PH_FILL;
      case (mode)
        MODE_ROT, MODE_BNC: dout_d = SEED_ONE;
        MODE_FILL:          dout_d = ALL_ZERO;
        default:            dout_d = SEED_INV;
      endcase
    end else if (tick) begin
      cnt_d  = '0;
      step_d = 1'b1;
      case (mode_q)
        MODE_BNC: begin
          if (bdir_q == DIR_LEFT && dout_q[WIDTH-1]) begin
            bdir_d = DIR_RIGHT;
            dout_d = dout_q >> 1;
          end else if (bdir_q == DIR_RIGHT && dout_q[0]) begin
            bdir_d = DIR_LEFT;
            dout_d = dout_q << 1;
          end else if (bdir_q == DIR_LEFT) begin
            dout_d = dout_q << 1;
          end else begin
            dout_d = dout_q >> 1;
          end
        end
        MODE_FILL: begin
          dout_d = fill_next;
          if (fill_next == ALL_ONES)      phase_d = PH_DRAIN;
          else if (fill_next == ALL_ZERO) phase_d = PH_FILL;
        end
        default: begin
          dout_d = rt ? {dout_q[0], dout_q[WIDTH-1:1]}
                      : {dout_q[WIDTH-2:0], dout_q[WIDTH-1]};
        end
      endcase
    end else if (!pause) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      mode_q  <= MODE_ROT;
      dout_q  <= SEED_ONE;
      step_q  <= 1'b0;
      bdir_q  <= DIR_LEFT;
      phase_q <= PH_FILL;
    end else begin
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      dout_q  <= dout_d;
      step_q  <= step_d;
      bdir_q  <= bdir_d;
      phase_q <= phase_d;
    end
  end

  assign dout = dout_q;
  assign step = step_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Directed bench for led_pattern_engine (WIDTH=5, SLOW_DIV=4, FAST_DIV=2).
module tb_led_pattern_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       pause;
  logic       fast;
  logic       rt;
  logic [1:0] mode;
  logic [4:0] dout;
  logic       step;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;
  logic [4:0]  cur;

  led_pattern_engine #(.WIDTH(5), .SLOW_DIV(4), .FAST_DIV(2)) dut (
    .clk   (clk),
    .reset (reset),
    .pause (pause),
    .fast  (fast),
    .rt    (rt),
    .mode  (mode),
    .dout  (dout),
    .step  (step)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %b expected %b", tag, got[4:0], exp[4:0]);
    end
  endtask

  // One clock edge, then check dout and step shortly after it.
  task automatic edge_chk(input string tag, input logic [4:0] exp_d, input logic exp_s);
    @(posedge clk);
    #1;
    check({tag, "_dout"}, 32'(dout), 32'(exp_d));
    check({tag, "_step"}, 32'(step), 32'(exp_s));
  endtask

  // Advance one full step period of div edges; only the last edge steps.
  task automatic adv(input string tag, input int div, input logic [4:0] exp_d);
    for (int i = 0; i < div - 1; i++) edge_chk({tag, "_hold"}, cur, 1'b0);
    edge_chk(tag, exp_d, 1'b1);
    cur = exp_d;
  endtask

  logic [4:0] bounce_seq [9] = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b01000,
                                 5'b00100, 5'b00010, 5'b00001, 5'b00010};
  logic [4:0] fill_seq0 [10] = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111,
                                 5'b11110, 5'b11100, 5'b11000, 5'b10000, 5'b00000};
  logic [4:0] fill_seq1 [6]  = '{5'b10000, 5'b11000, 5'b11100, 5'b11110, 5'b11111,
                                 5'b01111};

  initial begin
    reset = 1'b1; pause = 1'b0; fast = 1'b1; rt = 1'b1; mode = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dout", 32'(dout), 32'(5'b00001));
    check("rst_step", 32'(step), 32'(1'b0));
    reset = 1'b0;
    cur = 5'b00001;

    // Right rotate at div=2.
    adv("rot_r1", 2, 5'b10000);
    adv("rot_r2", 2, 5'b01000);

    // Pause for 5 cycles, one cycle after a step; count resumes at 1.
    edge_chk("pre_pause", cur, 1'b0);
    pause = 1'b1;
    for (int i = 0; i < 5; i++) edge_chk("paused", cur, 1'b0);
    pause = 1'b0;
    edge_chk("resume", 5'b00100, 1'b1);
    cur = 5'b00100;

    // Left rotate at div=4 with wrap, then slow-to-fast switch at cnt=2.
    rt = 1'b0; fast = 1'b0;
    adv("rot_l1", 4, 5'b01000);
    adv("rot_l2", 4, 5'b10000);
    adv("rot_wrap", 4, 5'b00001);
    edge_chk("cnt1", cur, 1'b0);
    edge_chk("cnt2", cur, 1'b0);
    fast = 1'b1;
    edge_chk("fast_sw", 5'b00010, 1'b1);
    cur = 5'b00010;

    // Bounce: reload then period-8 sweep; rt toggled mid-way has no effect.
    mode = 2'b01;
    edge_chk("bnc_reload", 5'b00001, 1'b0);
    cur = 5'b00001;
    for (int i = 0; i < 9; i++) begin
      if (i == 3) rt = 1'b1;
      if (i == 6) rt = 1'b0;
      adv("bounce", 2, bounce_seq[i]);
    end

    // Fill/drain left, then continue filling from the right.
    mode = 2'b10; rt = 1'b0;
    edge_chk("fill_reload", 5'b00000, 1'b0);
    cur = 5'b00000;
    for (int i = 0; i < 10; i++) adv("fill_l", 2, fill_seq0[i]);
    rt = 1'b1;
    for (int i = 0; i < 6; i++) adv("fill_r", 2, fill_seq1[i]);

    // Inverted rotate right.
    mode = 2'b11; rt = 1'b1;
    edge_chk("inv_reload", 5'b11110, 1'b0);
    cur = 5'b11110;
    adv("inv1", 2, 5'b01111);
    adv("inv2", 2, 5'b10111);

    // Asynchronous reset between edges while step is high.
    #2 reset = 1'b1;
    #1;
    check("async_rst_dout", 32'(dout), 32'(5'b00001));
    check("async_rst_step", 32'(step), 32'(1'b0));
    @(posedge clk);
    #3 reset = 1'b0;
    edge_chk("post_rst_reload", 5'b11110, 1'b0);
    cur = 5'b11110;
    adv("post_rst_inv", 2, 5'b01111);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/led_pattern_engine.md
# led_pattern_engine

Parametrised LED pattern generator, successor to the 5-bit rotating-LED block. It drives a WIDTH-bit LED bus with one of four selectable patterns: rotate, bounce, fill/drain and inverted rotate. Step rate comes from an internal prescaler with two programmable divisors. Pause, direction and speed controls are retained, and a step strobe is added for downstream display/sync logic.

## Interface
- WIDTH, 5, LED bus width; legal range WIDTH >= 2.
- SLOW_DIV, 4, clock cycles per step when fast=0; must be >= 1.
- FAST_DIV, 2, clock cycles per step when fast=1; must be >= 1 and <= SLOW_DIV.
- clk  input  1  single clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- pause  input  1  1 = freeze prescaler and pattern.
- fast  input  1  1 = use FAST_DIV, 0 = use SLOW_DIV.
- rt  input  1  direction: 1 = shift toward LSB (right), 0 = toward MSB (left); ignored in bounce mode.
- mode  input  2  00 rotate, 01 bounce, 10 fill/drain, 11 inverted rotate.
- dout  output  WIDTH  LED pattern.
- step  output  1  one-cycle pulse, high in the cycle dout shows a new stepped value.

## Operation
- Reset (async) sets:
  - dout = 0…01 and step = 0.
  - Prescaler cnt = 0 and mode_q = 00.
  - Bounce direction bdir = LEFT; fill phase = FILL.
- Prescaler behaviour:
  - Width is clog2(SLOW_DIV), minimum 1 bit; div = fast ? FAST_DIV : SLOW_DIV.
  - A tick occurs when !pause and cnt >= div-1; on a tick, cnt becomes 0.
  - If !pause and no tick, cnt increments by 1; if pause, cnt holds.
  - The >= compare makes a slow-to-fast switch mid-count tick immediately, with no wrap-around wait.
- Mode reload:
  - If mode != mode_q at an edge, mode_q takes mode and dout loads the seed: 00/01 give 0…01, 10 gives 0…0, 11 gives 1…10.
  - The same edge sets cnt = 0, bdir = LEFT, phase = FILL and step = 0.
  - Reload has priority over tick and is not blocked by pause.
  - A mode pin differing from 00 at reset release reloads on the first edge.
- Step action on a tick (no reload):
  - Rotate (00) and inverted rotate (11): circular shift. With rt=1, dout = {dout[0], dout[W-1:1]}; with rt=0, dout = {dout[W-2:0], dout[W-1]}.
  - Bounce (01), one-hot, rt ignored:
    - bdir=LEFT and dout[W-1]=1: set bdir=RIGHT and shift right.
    - bdir=RIGHT and dout[0]=1: set bdir=LEFT and shift left.
    - Otherwise shift in the bdir direction, filling with 0.
    - Period is 2·WIDTH-2 steps.
  - Fill/drain (10), shift-in bit b = (phase==FILL):
    - rt=0: dout = {dout[W-2:0], b}; rt=1: dout = {b, dout[W-1:1]}.
    - The phase flips when the new dout is all-ones (FILL→DRAIN) or all-zeros (DRAIN→FILL).
    - Period is 2·WIDTH steps.
- Changing rt mid-pattern takes effect on the next tick and needs no reload.
- Changing fast or pause alone never reloads the pattern.

## Timing
- All state is registered and dout is a direct register output; there are no combinational input-to-output paths.
- Step latency:
  - step is registered: step=1 in exactly the cycles following a tick edge, i.e. coincident with the new dout.
  - After reset release with a steady mode, the first dout change is at edge number div; with div=1, every edge steps.
- Pause and simultaneous events:
  - Pause asserted on the would-be tick edge suppresses that tick.
  - On resume, the remaining count continues, with no prescaler restart.
- Reset mid-count or mid-pattern returns all state to reset values immediately, without waiting for clk.

## Test plan
Default configuration for all scenarios is WIDTH=5, SLOW_DIV=4, FAST_DIV=2.
1. Reset, then mode=00, rt=1, fast=1 → dout 00001, then 10000, 01000, 00100 at every 2nd edge; step high one cycle per change.
2. During scenario 1, pause=1 for 5 cycles, starting one cycle after a step → dout and step frozen; after release, the next step comes 1 edge later (cnt resumes at 1).
3. mode=00, rt=0, fast=0 → left rotation every 4 clocks: 00001, 00010, …, 10000, then wraps to 00001. Switching fast=1 when cnt=2 → step on the very next edge.
4. mode changed to 01 → the next edge reloads 00001 with step=0. Steps then give 00010, 00100, 01000, 10000, 01000, 00100, 00010, 00001, 00010 (period 8); toggling rt has no effect.
5. mode=10, rt=0 → reload 00000, then 00001, 00011, …, 11111, 11110, …, 10000, 00000 (10 steps); repeat with rt=1 → 10000, 11000, …, 11111, 01111, ….
6. mode=11, rt=1 → reload 11110, then 01111, 10111. Asserting reset between clock edges → dout=00001 and step=0 without a clock edge; after release with mode=11 → reload 11110 on the first edge.
